// File: rtl/sram_pkg.sv
// Shared encodings for the 1024x8 SRAM controller and its bus-side sequencer:
// op/state codes, status bit positions, the command word layout and the FSM states.
package sram_pkg;

    localparam logic [7:0] ST_IDLE  = 8'h01;
    localparam logic [7:0] ST_SPLIT = 8'h02;
    localparam logic [7:0] ST_W_ALL = 8'h04;
    localparam logic [7:0] ST_R_ALL = 8'h08;
    localparam logic [7:0] ST_W_ONE = 8'h10;
    localparam logic [7:0] ST_R_ONE = 8'h20;
    localparam logic [7:0] ST_R_REG = 8'h40;
    localparam logic [7:0] ST_ERROR = 8'hFF;

    localparam int STAT_CHG = 8;
    localparam int STAT_FIN = 9;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  data;
        logic [15:0] addr;
    } cmd_t;

    localparam cmd_t CMD_PARK = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALL,
        S_RALL,
        S_RREG,
        S_NEXT,
        S_END
    } seq_state_e;

    function automatic cmd_t mk_cmd(input logic [7:0] op, input logic [7:0] data,
                                    input logic [15:0] addr);
        cmd_t c;
        c.op   = op;
        c.data = data;
        c.addr = addr;
        return c;
    endfunction

endpackage

// File: rtl/sram_test_chk.sv
// Read-back checker: counts data mismatches (saturating at 2**(AW+1)) and
// captures the address and data of the first one.
module sram_test_chk #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          sample_en,
    input  logic [DW-1:0] exp,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [AW+1:0] err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data
);

    localparam logic [AW+1:0] ERR_MAX = {2'b10, {AW{1'b0}}};

    logic mismatch;
    assign mismatch = sample_en && (rd_data != exp);

    // NOTE: state is updated with non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (clr) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (mismatch) begin
            if (err_cnt == '0) begin
                first_err_addr <= rd_addr;
                first_err_data <= rd_data;
            end
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_test_seq.sv
// Two-pass pattern test sequencer sitting upstream of the SRAM controller:
// writes P, reads back and compares, repeats with ~P, reports to the host.
module sram_test_seq
    import sram_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int TO_W = 16,
    parameter logic [TO_W-1:0] TIMEOUT = TO_W'(4096)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] pattern,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic          abort,
    output logic [AW+1:0] err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data,
    output logic [31:0]   cmd,
    input  logic [31:0]   status,
    input  logic [31:0]   outp_data,
    input  logic [31:0]   outp_addr
);

    seq_state_e state, state_nxt;
    cmd_t       cmd_q, cmd_nxt;
    logic       busy_nxt, done_nxt, pass_nxt, timeout_nxt, abort_nxt;
    logic       pass_sel, pass_sel_nxt;
    logic [DW-1:0] pat, pat_nxt, exp_data;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt, rd_ptr_inc;
    logic [TO_W-1:0] wd_cnt;
    logic [7:0] st_code, st_q, exp_op;
    logic       chg_q, op_seen;
    logic       chg_rise, op_done, sample_en, last_addr, clr;
    logic       wd_clr, wd_hit, ctl_err, stop;
    logic       unused_bits;

    assign st_code    = status[7:0];
    assign chg_rise   = status[STAT_CHG] && !chg_q;
    assign exp_op     = (state == S_RALL) ? ST_R_ALL : ST_W_ALL;
    // Completion = the issued op was observed and the controller is back in IDLE.
    assign op_done    = op_seen && (st_code == ST_IDLE);
    assign sample_en  = (state == S_RREG) && (st_code == ST_R_REG) && status[STAT_FIN]
                        && (outp_addr[AW-1:0] == rd_ptr);
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign last_addr  = (rd_ptr == '1);
    assign exp_data   = pass_sel ? ~pat : pat;
    assign clr        = (state == S_IDLE) && start;

    assign wd_clr  = (st_code != st_q) || sample_en;
    assign wd_hit  = busy && (state != S_END) && !wd_clr && (wd_cnt == TIMEOUT - 1'b1);
    assign ctl_err = busy && (st_code == ST_ERROR) && (state inside {S_WALL, S_RALL, S_RREG});
    assign stop    = wd_hit || ctl_err;

    assign cmd = cmd_q;
    assign unused_bits = ^{status[31:10], outp_data[31:DW], outp_addr[31:AW]};

    sram_test_chk #(.AW(AW), .DW(DW)) u_chk (
        .clk            (clk),
        .reset_n        (reset_n),
        .clr            (clr),
        .sample_en      (sample_en),
        .exp            (exp_data),
        .rd_addr        (rd_ptr),
        .rd_data        (outp_data[DW-1:0]),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_WALL;
            S_WALL: if (op_done) state_nxt = S_RALL;
            S_RALL: if (op_done) state_nxt = S_RREG;
            S_RREG: if (sample_en && last_addr) state_nxt = S_NEXT;
            S_NEXT: state_nxt = pass_sel ? S_END : S_WALL;
            S_END:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (stop) state_nxt = S_END;
    end

    always_comb begin
        cmd_nxt      = cmd_q;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        pass_nxt     = pass;
        timeout_nxt  = timeout;
        abort_nxt    = abort;
        pat_nxt      = pat;
        pass_sel_nxt = pass_sel;
        rd_ptr_nxt   = rd_ptr;
        case (state)
            S_IDLE: if (start) begin
                pat_nxt      = pattern;
                pass_nxt     = 1'b0;
                timeout_nxt  = 1'b0;
                abort_nxt    = 1'b0;
                pass_sel_nxt = 1'b0;
                busy_nxt     = 1'b1;
                cmd_nxt      = mk_cmd(ST_W_ALL, 8'(pattern), 16'h0);
            end
            S_WALL: if (chg_rise && st_code == ST_W_ALL)
                cmd_nxt = mk_cmd(ST_R_ALL, 8'h0, 16'h0);
            S_RALL: if (chg_rise && st_code == ST_R_ALL) begin
                cmd_nxt    = mk_cmd(ST_R_REG, 8'h0, 16'h0);
                rd_ptr_nxt = '0;
            end
            S_RREG: if (sample_en) begin
                rd_ptr_nxt = rd_ptr_inc;
                cmd_nxt    = last_addr ? CMD_PARK
                           : mk_cmd(ST_R_REG, 8'h0, {{(16-AW){1'b0}}, rd_ptr_inc});
            end
            S_NEXT: if (!pass_sel) begin
                pass_sel_nxt = 1'b1;
                cmd_nxt      = mk_cmd(ST_W_ALL, 8'(~pat), 16'h0);
            end
            S_END: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
                pass_nxt = (err_cnt == '0) && !abort && !timeout;
                cmd_nxt  = CMD_PARK;
            end
            default: ;
        endcase
        if (stop) begin
            timeout_nxt = timeout | wd_hit;
            abort_nxt   = abort | ctl_err;
            cmd_nxt     = CMD_PARK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q    <= CMD_PARK;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            abort    <= 1'b0;
            pat      <= '0;
            pass_sel <= 1'b0;
            rd_ptr   <= '0;
        end else begin
            cmd_q    <= cmd_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            pass     <= pass_nxt;
            timeout  <= timeout_nxt;
            abort    <= abort_nxt;
            pat      <= pat_nxt;
            pass_sel <= pass_sel_nxt;
            rd_ptr   <= rd_ptr_nxt;
        end
    end

    // Edge/change history for status plus the per-op "issued code seen" flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_IDLE;
            chg_q   <= 1'b0;
            op_seen <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            st_q  <= st_code;
            chg_q <= status[STAT_CHG];
            if (state_nxt != state)       op_seen <= 1'b0;
            else if (st_code == exp_op)   op_seen <= 1'b1;
            if (wd_clr || !busy) wd_cnt <= '0;
            else                 wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_test_seq.sv
// Bench for sram_test_seq: behavioural SRAM controller + memory with fault modes,
// a result/command-sequence model, and directed scenarios.
module tb_sram_test_seq;
    import sram_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] pattern = '0;
    logic          busy, done, pass, timeout, abort;
    logic [AW+1:0] err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data;
    logic [31:0]   cmd, status, outp_data, outp_addr;

    always #5 clk = ~clk;

    sram_test_seq dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .pattern        (pattern),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .abort          (abort),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .cmd            (cmd),
        .status         (status),
        .outp_data      (outp_data),
        .outp_addr      (outp_addr)
    );

    // Controller + memory model. fault_mode: 0 clean, 1 bit3 stuck-at-1 at 0x155,
    // 2 every read returns 0, 3 controller freezes in W_ALL.
    int         fault_mode = 0;
    logic       force_ff = 1'b0;
    logic [7:0] mem [1024];
    logic [7:0] c_st, c_wd, c_rdata;
    logic [9:0] c_a, c_raddr;
    logic       c_chg, c_fin;

    function automatic logic [7:0] rd_fn(input logic [9:0] a);
        if (fault_mode == 1 && a == 10'h155) return mem[a] | 8'h08;
        if (fault_mode == 2) return 8'h00;
        return mem[a];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_st <= ST_IDLE; c_a <= '0; c_chg <= 1'b0; c_fin <= 1'b0;
            c_wd <= '0; c_rdata <= '0; c_raddr <= '0;
        end else begin
            c_chg <= 1'b0;
            c_fin <= 1'b0;
            case (c_st)
                ST_IDLE: begin
                    case (cmd[31:24])
                        ST_W_ALL: begin c_st <= ST_W_ALL; c_a <= '0; c_wd <= cmd[23:16]; end
                        ST_R_ALL: begin c_st <= ST_R_ALL; c_a <= '0; end
                        ST_R_REG: begin
                            c_st <= ST_R_REG; c_fin <= 1'b1;
                            c_raddr <= cmd[9:0]; c_rdata <= rd_fn(cmd[9:0]);
                        end
                        8'h00:   c_st <= ST_IDLE;
                        default: c_st <= ST_ERROR;
                    endcase
                end
                ST_W_ALL: if (fault_mode != 3) begin
                    mem[c_a] <= c_wd;
                    c_a <= c_a + 1'b1;
                    if (c_a == 10'd1022) c_chg <= 1'b1;
                    if (c_a == 10'd1023) c_st <= ST_IDLE;
                end
                ST_R_ALL: begin
                    c_a <= c_a + 1'b1;
                    if (c_a == 10'd1022) c_chg <= 1'b1;
                    if (c_a == 10'd1023) c_st <= ST_IDLE;
                end
                default: c_st <= ST_IDLE;
            endcase
        end
    end

    assign status    = {22'h0, c_fin, c_chg, force_ff ? 8'hFF : c_st};
    assign outp_data = {24'h0, c_rdata};
    assign outp_addr = {22'h0, c_raddr};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        n_tests++;
        n_fail++;
        $display("FAIL %s: waited %0d cycles without the expected event, limit reached", name, waited);
    endtask

    // Reference model: expected final results derived from the test rules alone.
    logic [31:0] exp_cmd_q[$];
    int          exp_cnt, exp_fa, exp_fd;
    logic        exp_pass, exp_to, exp_ab;
    logic        chk_cmd = 1'b0, arm = 1'b0, done_seen = 1'b0;

    task automatic model_result(input int mode, input logic [7:0] p);
        exp_cnt = 0; exp_fa = 0; exp_fd = 0;
        for (int ps = 0; ps < 2; ps++) begin
            for (int a = 0; a < 1024; a++) begin
                logic [7:0] w, r;
                w = (ps == 1) ? ~p : p;
                r = w;
                if (mode == 1 && a == 'h155) r = w | 8'h08;
                if (mode == 2) r = 8'h00;
                if (r != w) begin
                    if (exp_cnt == 0) begin exp_fa = a; exp_fd = int'(r); end
                    if (exp_cnt < 2048) exp_cnt++;
                end
            end
        end
        exp_pass = (exp_cnt == 0);
        exp_to = 1'b0;
        exp_ab = 1'b0;
    endtask

    task automatic build_cmd_q(input logic [7:0] p);
        exp_cmd_q.delete();
        for (int ps = 0; ps < 2; ps++) begin
            exp_cmd_q.push_back({ST_W_ALL, (ps == 1) ? ~p : p, 16'h0});
            exp_cmd_q.push_back({ST_R_ALL, 24'h0});
            for (int a = 0; a < 1024; a++) exp_cmd_q.push_back({ST_R_REG, 8'h0, 16'(a)});
            exp_cmd_q.push_back(32'h0);
        end
    endtask

    // Compare process: command sequence on every change, results on done.
    logic [31:0] last_cmd = 32'h0;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            last_cmd  = 32'h0;
            prev_done = 1'b0;
        end else begin
            if (chk_cmd && cmd !== last_cmd) begin
                if (exp_cmd_q.size() == 0) check("cmd_extra", cmd, last_cmd);
                else check("cmd_seq", cmd, exp_cmd_q.pop_front());
            end
            last_cmd = cmd;
            if (prev_done) check("done_pulse", {31'h0, done}, 32'h0);
            if (done && arm) begin
                arm = 1'b0;
                done_seen = 1'b1;
                check("res_pass", {31'h0, pass}, {31'h0, exp_pass});
                check("res_err_cnt", {20'h0, err_cnt}, exp_cnt);
                check("res_first_addr", {22'h0, first_err_addr}, exp_fa);
                check("res_first_data", {24'h0, first_err_data}, exp_fd);
                check("res_timeout", {31'h0, timeout}, {31'h0, exp_to});
                check("res_abort", {31'h0, abort}, {31'h0, exp_ab});
                check("res_busy", {31'h0, busy}, 32'h0);
            end
            prev_done = done;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_pass"}, {31'h0, pass}, 32'h0);
        check({tag, "_timeout"}, {31'h0, timeout}, 32'h0);
        check({tag, "_abort"}, {31'h0, abort}, 32'h0);
        check({tag, "_err_cnt"}, {20'h0, err_cnt}, 32'h0);
        check({tag, "_first_addr"}, {22'h0, first_err_addr}, 32'h0);
        check({tag, "_first_data"}, {24'h0, first_err_data}, 32'h0);
        check({tag, "_cmd"}, cmd, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        force_ff = 1'b0;
        #1 check_reset_vals("rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_start(input logic [7:0] p);
        @(negedge clk);
        pattern = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_seen) bound_fail(name, cyc);
    endtask

    task automatic wait_cmd(input string name, input logic [7:0] op, input int min_addr);
        int n = 0;
        while (!(cmd[31:24] == op && int'(cmd[15:0]) >= min_addr) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) bound_fail(name, n);
    endtask

    task automatic run_full(input string name, input int mode, input logic [7:0] p,
                            input logic busy_start);
        int cyc;
        do_reset();
        fault_mode = mode;
        model_result(mode, p);
        build_cmd_q(p);
        chk_cmd = 1'b1;
        done_seen = 1'b0;
        arm = 1'b1;
        pulse_start(p);
        if (busy_start) begin
            wait_cmd({name, "_wait_rall"}, ST_R_ALL, 0);
            pulse_start(8'h00);
        end
        wait_done(name, 20000, cyc);
        check({name, "_cmd_left"}, exp_cmd_q.size(), 32'h0);
        chk_cmd = 1'b0;
    endtask

    initial begin
        int cyc;

        // Directed run 1: clean memory, P=A5, plus a start pulse while busy.
        run_full("clean_a5", 0, 8'hA5, 1'b1);
        check("clean_a5_pass", {31'h0, pass}, 32'h1);
        check("clean_a5_err", {20'h0, err_cnt}, 32'h0);
        check("clean_a5_cmd", cmd, 32'h0);

        // Stuck-at-1 on bit 3 at 0x155: only the P pass mismatches.
        run_full("stuck", 1, 8'hA5, 1'b0);
        check("stuck_pass", {31'h0, pass}, 32'h0);
        check("stuck_err", {20'h0, err_cnt}, 32'd1);
        check("stuck_addr", {22'h0, first_err_addr}, 32'h155);
        check("stuck_data", {24'h0, first_err_data}, 32'hAD);

        // All reads return 0 with P=FF: every address fails in the first pass.
        run_full("zeros", 2, 8'hFF, 1'b0);
        check("zeros_err", {20'h0, err_cnt}, 32'd1024);
        check("zeros_addr", {22'h0, first_err_addr}, 32'h0);
        check("zeros_data", {24'h0, first_err_data}, 32'h0);
        check("zeros_pass", {31'h0, pass}, 32'h0);

        // Controller freezes in W_ALL: watchdog ends the test.
        do_reset();
        fault_mode = 3;
        exp_cnt = 0; exp_fa = 0; exp_fd = 0;
        exp_pass = 1'b0; exp_to = 1'b1; exp_ab = 1'b0;
        done_seen = 1'b0;
        arm = 1'b1;
        pulse_start(8'h55);
        wait_done("timeout_done", 6000, cyc);
        check("timeout_window", {31'h0, (cyc >= 4090 && cyc <= 4110)}, 32'h1);
        check("timeout_flag", {31'h0, timeout}, 32'h1);
        check("timeout_busy", {31'h0, busy}, 32'h0);
        check("timeout_pass", {31'h0, pass}, 32'h0);

        // Controller reports ERROR during the register read-back phase.
        do_reset();
        fault_mode = 0;
        exp_cnt = 0; exp_fa = 0; exp_fd = 0;
        exp_pass = 1'b0; exp_to = 1'b0; exp_ab = 1'b1;
        done_seen = 1'b0;
        arm = 1'b1;
        pulse_start(8'h96);
        wait_cmd("abort_wait_rreg", ST_R_REG, 16);
        force_ff = 1'b1;
        @(negedge clk);
        check("abort_flag", {31'h0, abort}, 32'h1);
        check("abort_cmd", cmd, 32'h0);
        check("abort_done_early", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("abort_done", {31'h0, done}, 32'h1);
        force_ff = 1'b0;
        wait_done("abort_done_seen", 5, cyc);

        // Reset in the middle of S_RREG, then a clean rerun with P=3C.
        do_reset();
        fault_mode = 2;
        arm = 1'b0;
        pulse_start(8'h3C);
        wait_cmd("mid_wait_rreg", ST_R_REG, 20);
        check("mid_err_before", {20'h0, err_cnt}, 32'd20);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_full("rerun_3c", 0, 8'h3C, 1'b0);
        check("rerun_pass", {31'h0, pass}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_time_limit: simulation did not finish, limit %0d", 3000000);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sram_test_seq.md
Name: sram_test_seq

Overview:
- Upstream bus-side sequencer for the 1024x8 SRAM controller.
- Drives the controller's 32-bit cmd word, watches its status word, and harvests R_REG results.
- Runs a two-pass pattern test: write pattern P, cache the array, read back and compare; then repeat with ~P.
- Reports pass/fail, error count, first failing address/data and timeout to a host register block.

Parameters:
- AW, 10, SRAM address width; depth = 2**AW = 1024.
- DW, 8, SRAM data width.
- TO_W, 16, watchdog counter width.
- TIMEOUT, 16'd4096, maximum cycles without controller progress before abort.

Ports:
- clk  in  1  system clock (controller and SRAM share it)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a test when idle
- pattern  in  DW  base pattern P, latched on start
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at end of test (normal, error-abort or timeout)
- pass  out  1  sticky; 1 if last test saw err_cnt==0 with no abort/timeout
- timeout  out  1  sticky; watchdog expired in last test
- abort  out  1  sticky; controller reported ERROR state (status[7:0]==8'hFF) mid-test
- err_cnt  out  AW+2  mismatches counted across both passes (max 2048)
- first_err_addr  out  AW  address of first mismatch
- first_err_data  out  DW  data read at first mismatch
- cmd  out  32  to controller: [31:24] op, [23:16] data, [15:0] addr
- status  in  32  from controller: [7:0] one-hot state, [8] change-cmd, [9] finish
- outp_data  in  32  from controller; [7:0] is read data
- outp_addr  in  32  from controller; [AW-1:0] is read address

Behaviour:
- Op codes / status state codes: IDLE 8'h01, W_ALL 8'h04, R_ALL 8'h08, R_REG 8'h40, ERROR 8'hFF. Park command = 32'h0.
- Reset: cmd=0, busy=0, done=0, pass=0, timeout=0, abort=0, err_cnt=0, first_err_addr=0, first_err_data=0; FSM in S_IDLE.
- Controller re-latches cmd on every pass through its IDLE state. cmd is therefore always registered and held stable. It changes only on the rising edge of status[8], or after an op has completed.
- Op completion: status[7:0] was seen equal to the issued op code and then returns to 8'h01. status[9] is not relied on, because R_ALL never asserts it.
- FSM states: S_IDLE, S_WALL, S_RALL, S_RREG, S_NEXT, S_END.
- S_IDLE:
  - On start: latch P, clear err_cnt/pass/timeout/abort/first_err_*, set pass_sel=0, busy=1.
  - Drive cmd={8'h04, P, 16'h0}, go S_WALL.
  - start while busy is ignored.
- S_WALL:
  - On status[8] rise with state 8'h04: cmd={8'h08, 8'h0, 16'h0}.
  - On completion: go S_RALL.
- S_RALL:
  - On status[8] rise with state 8'h08: cmd={8'h40, 8'h0, 16'h0}, rd_ptr=0.
  - On completion: go S_RREG.
- S_RREG:
  - Sample when status[7:0]==8'h40 && status[9] && outp_addr[AW-1:0]==rd_ptr. This sample rule makes the controller's duplicate R_REG of the same address harmless.
  - Compare outp_data[7:0] against exp (P when pass_sel=0, ~P when pass_sel=1).
  - On mismatch: err_cnt+1. If err_cnt was 0, record first_err_addr=rd_ptr and first_err_data=outp_data[7:0].
  - Then rd_ptr+1 and cmd addr field = rd_ptr+1 (zero-extended to 16 bits).
  - After sampling rd_ptr==1023: cmd=0 (park), go S_NEXT.
- S_NEXT:
  - If pass_sel=0: pass_sel=1, cmd={8'h04, ~P, 16'h0}, go S_WALL.
  - Else go S_END.
- S_END: one cycle; done=1, busy=0, pass=(err_cnt==0 && !abort && !timeout), cmd=0, go S_IDLE.
- Watchdog:
  - Counter clears on any change of status[7:0] and on each accepted R_REG sample.
  - Counts while busy. Reaching TIMEOUT sets timeout=1 and goes to S_END.
- Abort: status[7:0]==8'hFF while busy and in S_WALL/S_RALL/S_RREG sets abort=1 and goes to S_END.
- Simultaneous timeout and abort in the same cycle: both flags set.
- err_cnt saturates at 2048.
- Reset mid-test: all outputs return to reset values immediately (async). The controller then sees park cmd and enters ERROR/IDLE harmlessly.

Decomposition:
- Shared package sram_pkg holds the op/state code constants (IDLE, SPLIT, W_ALL, R_ALL, W_ONE, R_ONE, R_REG, ERROR), the status bit indices (CHG=8, FIN=9), the cmd field slices and the park command. The controller is migrated to use it.
- One natural sub-module, sram_test_chk: comparator, error counter and first-error capture, with inputs sample_en, exp, rd_addr, rd_data, clr.

Test Plan:
- Clean memory model behind the controller, P=8'hA5 -> done pulse, pass=1, err_cnt=0, cmd observed sequence W_ALL(A5), R_ALL, R_REG 0..1023, W_ALL(5A), R_ALL, R_REG 0..1023.
- Stuck-at-1 on bit 3 at addr 10'h155, P=8'hA5 -> pass=0, err_cnt=1, first_err_addr=10'h155, first_err_data=8'hAD (pass with ~P clean).
- Every address returns 8'h00, P=8'hFF -> err_cnt=1024, first_err_addr=0, first_err_data=8'h00, pass=0.
- Status held constant at 8'h04 after start -> after 4096 cycles timeout=1, done pulse, busy=0, pass=0.
- Force status[7:0]=8'hFF during R_RREG -> abort=1, done next cycle, cmd=32'h0.
- Assert reset_n low mid-S_RREG, then start again with P=8'h3C -> outputs at reset values during reset; second run completes with pass=1.
